io_in_deser: RTL and testbench

Serial-to-parallel capture stage directly downstream of the output register cell. It samples the 1-bit `F2A` stream on `IQC`, assembles `W`-bit words, and presents them to the fabric through a valid/ready holding register with a sticky overflow flag. Optionally it supports bit-slip word alignment.

---
 rtl/io_reg_pkg.sv | 21 ++
 rtl/io_in_deser_if.sv | 17 +
 rtl/io_in_deser_shift.sv | 74 +++++++
 rtl/io_in_deser.sv | 76 +++++++
 tb/tb_io_in_deser.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/io_reg_pkg.sv
// Shared constants and helpers for the serial input deserializer.
//   WMin/WMax : legal word-width bounds
//   WDefault  : default word width
//   clog2()   : bit-counter width for a given word width
package io_reg_pkg;

  localparam int unsigned WMin     = 2;
  localparam int unsigned WMax     = 32;
  localparam int unsigned WDefault = 8;

  // Smallest r with 2**r >= v; enough bits to count 0..v-1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/io_in_deser_if.sv
// Word handshake bundle between the deserializer and the fabric consumer.
//   WORD   : assembled word (producer -> consumer)
//   WVALID : holding register full (producer -> consumer)
//   WREADY : consumer accepts WORD (consumer -> producer)
// master = deserializer side, slave = consumer side.
interface io_in_deser_if
  import io_reg_pkg::*;
#(
  parameter int unsigned W = WDefault
);
  logic [W-1:0] WORD;
  logic         WVALID;
  logic         WREADY;

  modport master (output WORD, output WVALID, input WREADY);
  modport slave  (input WORD, input WVALID, output WREADY);
endinterface

// File: rtl/io_in_deser_shift.sv
// Serial shift register, bit counter and word-completion strobe.
// Optional feature macro: IO_DESER_BITSLIP_EN (adds i_bitslip and slip logic).
//   i_clk, i_rst_n : clock, async active-low reset
//   i_f2a, i_en    : serial bit and sample enable
//   i_bitslip      : alignment request (macro only)
//   o_done         : completion strobe, valid during the completing edge's cycle
//   o_word         : completed word (sr combined with current i_f2a)
module io_deser_shift
  import io_reg_pkg::*;
#(
  parameter int unsigned W         = WDefault,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_f2a,
  input  logic         i_en,
`ifdef IO_DESER_BITSLIP_EN
  input  logic         i_bitslip,
`endif
  output logic         o_done,
  output logic [W-1:0] o_word
);

  localparam int unsigned CW = clog2(W);
  localparam logic [CW-1:0] CntLast = CW'(W - 1);

  logic [W-2:0]  r_sr;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  w_word;
  logic [W-2:0]  w_sr_next;
  logic          w_slip;
  logic          w_last;

  // The full word view doubles as the shifted register: drop the oldest bit.
  assign w_word    = MSB_FIRST ? {r_sr, i_f2a} : {i_f2a, r_sr};
  assign w_sr_next = MSB_FIRST ? w_word[W-2:0] : w_word[W-1:1];
  assign w_last    = (r_cnt == CntLast);

`ifdef IO_DESER_BITSLIP_EN
  logic r_slip_prev;
  logic r_slip_pend;

  // A rising edge seen while disabled stays pending until the next enabled edge.
  assign w_slip = (i_bitslip & ~r_slip_prev) | r_slip_pend;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_slip_prev <= 1'b0;
      r_slip_pend <= 1'b0;
    end else begin
      r_slip_prev <= i_bitslip;
      r_slip_pend <= i_en ? 1'b0 : w_slip;
    end
  end
`else
  assign w_slip = 1'b0;
`endif

  // A slip on the last bit holds cnt at W-1, deferring completion one enabled edge.
  assign o_done = i_en & w_last & ~w_slip;
  assign o_word = w_word;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sr  <= '0;
      r_cnt <= '0;
    end else if (i_en) begin
      r_sr <= w_sr_next;
      if (!w_slip) r_cnt <= w_last ? '0 : r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/io_in_deser.sv
// Serial-to-parallel capture stage with a valid/ready holding register and a
// sticky overflow flag.
// Optional feature macro: IO_DESER_BITSLIP_EN (adds BITSLIP port).
//   IQC, QRT   : clock, async active-low reset
//   F2A, EN    : serial bit and sample enable
//   BITSLIP    : word-alignment request (macro only)
//   OVF        : sticky flag, a completed word was dropped
//   CLR_OVF    : synchronous clear of OVF (a same-edge overflow wins)
//   word_if    : WORD/WVALID/WREADY handshake (master side)
// W legal range 2..32.
module io_in_deser
  import io_reg_pkg::*;
#(
  parameter int unsigned W         = WDefault,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic          IQC,
  input  logic          QRT,
  input  logic          F2A,
  input  logic          EN,
`ifdef IO_DESER_BITSLIP_EN
  input  logic          BITSLIP,
`endif
  output logic          OVF,
  input  logic          CLR_OVF,
  io_in_deser_if.master word_if
);

  logic         w_done;
  logic [W-1:0] w_new_word;
  logic         w_accept;
  logic         w_drop;
  logic [W-1:0] r_word;
  logic         r_wvalid;
  logic         r_ovf;

  io_deser_shift #(
    .W         (W),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift (
    .i_clk     (IQC),
    .i_rst_n   (QRT),
    .i_f2a     (F2A),
    .i_en      (EN),
`ifdef IO_DESER_BITSLIP_EN
    .i_bitslip (BITSLIP),
`endif
    .o_done    (w_done),
    .o_word    (w_new_word)
  );

  assign w_accept = r_wvalid & word_if.WREADY;
  // No backpressure to the serial side: a word arriving at a full, stalled register is lost.
  assign w_drop   = w_done & r_wvalid & ~word_if.WREADY;

  always_ff @(posedge IQC or negedge QRT) begin
    if (!QRT) begin
      r_word   <= '0;
      r_wvalid <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_done && (!r_wvalid || word_if.WREADY)) begin
        r_word   <= w_new_word;
        r_wvalid <= 1'b1;
      end else if (w_accept) begin
        r_wvalid <= 1'b0;
      end
      r_ovf <= w_drop | (r_ovf & ~CLR_OVF);
    end
  end

  assign word_if.WORD   = r_word;
  assign word_if.WVALID = r_wvalid;
  assign OVF            = r_ovf;

endmodule

// File: tb/tb_io_in_deser.sv
// Directed self-checking bench for io_in_deser (W=8, MSB-first and LSB-first instances).
module tb_io_in_deser;
  import io_reg_pkg::*;

  logic iqc;
  logic qrt;
  logic f2a;
  logic en;
  logic clr_ovf;
  logic wready;
  logic ovf_m;
  logic ovf_l;
`ifdef IO_DESER_BITSLIP_EN
  logic bitslip;
`endif

  int n_checks;
  int n_fail;
  int bit_idx;

  io_in_deser_if #(.W(8)) if_m ();
  io_in_deser_if #(.W(8)) if_l ();

  assign if_m.WREADY = wready;
  assign if_l.WREADY = wready;

  io_in_deser #(.W(8), .MSB_FIRST(1'b1)) dut (
    .IQC     (iqc),
    .QRT     (qrt),
    .F2A     (f2a),
    .EN      (en),
`ifdef IO_DESER_BITSLIP_EN
    .BITSLIP (bitslip),
`endif
    .OVF     (ovf_m),
    .CLR_OVF (clr_ovf),
    .word_if (if_m)
  );

  io_in_deser #(.W(8), .MSB_FIRST(1'b0)) dut_lsb (
    .IQC     (iqc),
    .QRT     (qrt),
    .F2A     (f2a),
    .EN      (en),
`ifdef IO_DESER_BITSLIP_EN
    .BITSLIP (bitslip),
`endif
    .OVF     (ovf_l),
    .CLR_OVF (clr_ovf),
    .word_if (if_l)
  );

  initial begin
    iqc = 1'b0;
    forever #5 iqc = ~iqc;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive one bit, let one rising edge pass, return 1 time unit after it.
  task automatic step(input logic b, input logic e);
    f2a = b;
    en  = e;
    @(posedge iqc);
    #1;
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) step(w[i], 1'b1);
  endtask

  // Stream the repeating 0x0F pattern MSB first; optionally check every delivered word.
  task automatic send_pat(input int n, input logic [7:0] exp, input bit do_chk,
                          input string tag);
    logic [7:0] pat;
    int         seen;
    pat  = 8'h0F;
    seen = 0;
    for (int i = 0; i < n; i++) begin
      step(pat[7 - (bit_idx % 8)], 1'b1);
      bit_idx++;
      if (do_chk && if_m.WVALID) begin
        chk(tag, 32'(if_m.WORD), 32'(exp));
        seen++;
      end
    end
    if (do_chk) chk({tag, "_count"}, 32'(seen), 32'(n / 8));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    bit_idx  = 0;
    qrt      = 1'b0;
    f2a      = 1'b0;
    en       = 1'b0;
    clr_ovf  = 1'b0;
    wready   = 1'b1;
`ifdef IO_DESER_BITSLIP_EN
    bitslip  = 1'b0;
`endif
    #1;
    chk("rst_word", 32'(if_m.WORD), 32'h0);
    chk("rst_valid", 32'(if_m.WVALID), 32'h0);
    chk("rst_ovf", 32'(ovf_m), 32'h0);
    #2;
    qrt = 1'b1;

    // 1,0,1,1,0,0,1,0: MSB-first 0xB2, LSB-first 0x4D
    for (int i = 7; i >= 1; i--) step(i[0] ? 1'b0 : 1'b0, 1'b0);
    send_word(8'hB2);
    chk("b2_valid", 32'(if_m.WVALID), 32'h1);
    chk("b2_word", 32'(if_m.WORD), 32'hB2);
    chk("lsb_4d_word", 32'(if_l.WORD), 32'h4D);
    chk("lsb_4d_valid", 32'(if_l.WVALID), 32'h1);
    step(1'b0, 1'b0);
    chk("b2_valid_one_cycle", 32'(if_m.WVALID), 32'h0);
    chk("b2_word_hold", 32'(if_m.WORD), 32'hB2);

    // Overflow with consumer stalled
    wready = 1'b0;
    send_word(8'hA5);
    chk("a5_word", 32'(if_m.WORD), 32'hA5);
    chk("a5_ovf_clear", 32'(ovf_m), 32'h0);
    send_word(8'h3C);
    chk("ovf_word_kept", 32'(if_m.WORD), 32'hA5);
    chk("ovf_valid_kept", 32'(if_m.WVALID), 32'h1);
    chk("ovf_set", 32'(ovf_m), 32'h1);
    chk("ovf_set_lsb", 32'(ovf_l), 32'h1);
    clr_ovf = 1'b1;
    step(1'b0, 1'b0);
    clr_ovf = 1'b0;
    chk("ovf_cleared", 32'(ovf_m), 32'h0);
    chk("ovf_clr_word", 32'(if_m.WORD), 32'hA5);
    // Overflow and clear on the same edge: set wins
    for (int i = 7; i >= 1; i--) step(i[0], 1'b1);
    clr_ovf = 1'b1;
    step(1'b0, 1'b1);
    clr_ovf = 1'b0;
    chk("ovf_set_wins", 32'(ovf_m), 32'h1);
    clr_ovf = 1'b1;
    step(1'b0, 1'b0);
    clr_ovf = 1'b0;
    chk("ovf_cleared2", 32'(ovf_m), 32'h0);
    wready = 1'b1;
    step(1'b0, 1'b0);
    chk("drain_valid", 32'(if_m.WVALID), 32'h0);
    chk("drain_word", 32'(if_m.WORD), 32'hA5);

    // EN toggling; bits presented on disabled edges are inverted garbage
    begin
      logic [7:0] w;
      w = 8'hF0;
      for (int i = 7; i >= 0; i--) begin
        step(w[i], 1'b1);
        if (i == 4) chk("en_cnt_run", 32'(dut.u_shift.r_cnt), 32'd4);
        if (i == 0) begin
          chk("en_f0_word", 32'(if_m.WORD), 32'hF0);
          chk("en_f0_valid", 32'(if_m.WVALID), 32'h1);
        end
        step(~w[i], 1'b0);
        if (i == 4) chk("en_cnt_hold", 32'(dut.u_shift.r_cnt), 32'd4);
      end
    end

    // Async reset mid-word with a full register and OVF set
    wready = 1'b0;
    send_word(8'h55);
    send_word(8'h55);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1);
    chk("pre_rst_cnt", 32'(dut.u_shift.r_cnt), 32'd5);
    chk("pre_rst_ovf", 32'(ovf_m), 32'h1);
    #2;
    qrt = 1'b0;
    #1;
    chk("async_rst_word", 32'(if_m.WORD), 32'h0);
    chk("async_rst_valid", 32'(if_m.WVALID), 32'h0);
    chk("async_rst_ovf", 32'(ovf_m), 32'h0);
    chk("async_rst_cnt", 32'(dut.u_shift.r_cnt), 32'd0);
    qrt    = 1'b1;
    wready = 1'b1;
    send_word(8'h81);
    chk("post_rst_81", 32'(if_m.WORD), 32'h81);
    chk("post_rst_valid", 32'(if_m.WVALID), 32'h1);

`ifdef IO_DESER_BITSLIP_EN
    bit_idx = 0;
    send_pat(24, 8'h0F, 1'b1, "slip_pre");
    bitslip = 1'b1;
    send_pat(1, 8'h00, 1'b0, "slip_pulse");
    bitslip = 1'b0;
    send_pat(7, 8'h00, 1'b0, "slip_drain");
    send_pat(24, 8'h1E, 1'b1, "slip_one");
    bitslip = 1'b1;
    send_pat(10, 8'h00, 1'b0, "slip_hold");
    bitslip = 1'b0;
    send_pat(8, 8'h00, 1'b0, "slip_drain2");
    send_pat(24, 8'h3C, 1'b1, "slip_held_once");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
